tiny16_bus_responder: RTL

Memory-side responder for the tiny16 CPU bus. It answers the CPU's read and write strobes with a `ready` handshake, inserts a configurable number of wait states, and serves an on-chip RAM plus a small MMIO page. The MMIO page holds an output port, a free-running cycle counter and a sticky fault register. It sits between the CPU's `address`/`data_out`/`rd`/`wr` pins and its `data_in`/`ready` inputs.

---
 rtl/tiny16_bus_pkg.sv | 23 ++
 rtl/tiny16_ram.sv | 25 ++
 rtl/tiny16_bus_responder.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/tiny16_bus_pkg.sv
// Shared constants and types for the tiny16 bus responder.
package tiny16_bus_pkg;

    localparam logic [15:0] MMIO_PORT  = 16'hFF00;
    localparam logic [15:0] MMIO_CNT   = 16'hFF01;
    localparam logic [15:0] MMIO_FAULT = 16'hFF02;

    localparam int FAULT_UNMAPPED = 0;
    localparam int FAULT_BOTH     = 1;

    typedef enum logic [1:0] {NONE, RD, WR, BOTH} acc_kind_t;
    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    function automatic acc_kind_t decode_kind(input logic rd_n, input logic wr);
        case ({~rd_n, wr})
            2'b10:   return RD;
            2'b01:   return WR;
            2'b11:   return BOTH;
            default: return NONE;
        endcase
    endfunction

endpackage

// File: rtl/tiny16_ram.sv
// Single-port on-chip RAM; the read register only updates when en is set,
// so it keeps the last read word across intervening writes.
module tiny16_ram #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [15:0]          wdata,
    output logic [15:0]          rdata
);

    logic [15:0] mem [0:(1<<ADDR_BITS)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (en) begin
            rdata <= we ? wdata : mem[addr];
        end
    end

endmodule

// File: rtl/tiny16_bus_responder.sv
// tiny16 bus responder: wait-state handshake, RAM and MMIO page.
//   state | meaning
//   IDLE  | no access in progress, bus_ready high
//   WAIT  | access detected, burning the remaining wait states
//   ACK   | access complete, waiting for strobe release or a new access
module tiny16_bus_responder
    import tiny16_bus_pkg::*;
#(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bus_addr,
    input  logic [15:0] bus_wdata,
    input  logic        bus_rd_n,
    input  logic        bus_wr,
    output logic [15:0] bus_rdata,
    output logic        bus_ready,
    output logic [15:0] port_out,
    output logic        fault
);

    // The detection cycle is the first wait state, so WAIT covers the rest.
    localparam state_t      FIRST_NX  = (WAIT_STATES > 1) ? WAIT : ACK;
    localparam logic [15:0] WAIT_LOAD = (WAIT_STATES > 1) ? 16'(WAIT_STATES - 2) : 16'd0;

    state_t      state, state_nx;
    acc_kind_t   kind_now, prev_kind, lat_kind;
    logic [15:0] lat_addr, wcnt, port_q, cnt_q, cap_q, rdata_q, read_val, ram_q;
    logic [1:0]  fault_q;
    logic        cap_ram, rdata_sel_ram;
    logic        new_access, detect, is_ram, is_port, is_cnt, is_fault, mapped;
    logic        ram_rd, ram_wr, port_wr, cnt_load, fault_wr;

    assign kind_now   = decode_kind(bus_rd_n, bus_wr);
    assign new_access = (kind_now != NONE) &&
                        ((prev_kind == NONE) || (bus_addr != lat_addr) || (kind_now != lat_kind));
    assign detect     = new_access && ((state == IDLE) || (state == ACK));

    assign is_ram   = (bus_addr >> ADDR_BITS) == 16'd0;
    assign is_port  = bus_addr == MMIO_PORT;
    assign is_cnt   = bus_addr == MMIO_CNT;
    assign is_fault = bus_addr == MMIO_FAULT;
    assign mapped   = is_ram || is_port || is_cnt || is_fault;

    assign ram_rd   = detect && (kind_now == RD) && is_ram;
    assign ram_wr   = detect && (kind_now == WR) && is_ram;
    assign port_wr  = detect && (kind_now == WR) && is_port;
    assign cnt_load = detect && (kind_now == WR) && is_cnt;
    assign fault_wr = detect && (kind_now == WR) && is_fault;

    always_comb begin
        read_val = 16'h0000;
        if (kind_now == RD) begin
            if (is_port) begin
                read_val = port_q;
            end else if (is_cnt) begin
                read_val = cnt_q;
            end else if (is_fault) begin
                read_val = {14'd0, fault_q};
            end
        end
    end

    tiny16_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
        .clk   (clk),
        .en    (ram_rd),
        .we    (ram_wr),
        .addr  (bus_addr[ADDR_BITS-1:0]),
        .wdata (bus_wdata),
        .rdata (ram_q)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        bus_ready = 1'b1;
        unique case (state)
            IDLE: begin
                if (new_access) begin
                    bus_ready = 1'b0;
                    state_nx  = FIRST_NX;
                end
            end
            WAIT: begin
                bus_ready = 1'b0;
                if (wcnt == 16'd0) begin
                    state_nx = ACK;
                end
            end
            ACK: begin
                if (new_access) begin
                    bus_ready = 1'b0;
                    state_nx  = FIRST_NX;
                end else if (kind_now == NONE) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_kind     <= NONE;
            lat_kind      <= NONE;
            lat_addr      <= '0;
            wcnt          <= '0;
            port_q        <= '0;
            cnt_q         <= '0;
            fault_q       <= '0;
            cap_q         <= '0;
            cap_ram       <= 1'b0;
            rdata_q       <= '0;
            rdata_sel_ram <= 1'b0;
        end else begin
            prev_kind <= kind_now;
            cnt_q     <= cnt_load ? bus_wdata : cnt_q + 16'd1;
            if (detect) begin
                lat_addr <= bus_addr;
                lat_kind <= kind_now;
                wcnt     <= WAIT_LOAD;
                cap_q    <= read_val;
                cap_ram  <= ram_rd;
                if (port_wr) begin
                    port_q <= bus_wdata;
                end
                if (fault_wr) begin
                    fault_q <= '0;
                end
                if (!mapped) begin
                    fault_q[FAULT_UNMAPPED] <= 1'b1;
                end
                if (kind_now == BOTH) begin
                    fault_q[FAULT_BOTH] <= 1'b1;
                end
                // With no WAIT state the RAM word arrives with ACK, so select it live.
                if ((WAIT_STATES == 1) && (kind_now != WR)) begin
                    rdata_q       <= read_val;
                    rdata_sel_ram <= ram_rd;
                end
            end else if (state == WAIT) begin
                if (wcnt != 16'd0) begin
                    wcnt <= wcnt - 16'd1;
                end else if (lat_kind != WR) begin
                    rdata_q       <= cap_ram ? ram_q : cap_q;
                    rdata_sel_ram <= 1'b0;
                end
            end
        end
    end

    assign bus_rdata = rdata_sel_ram ? ram_q : rdata_q;
    assign port_out  = port_q;
    assign fault     = |fault_q;

endmodule
